// File: rtl/dcache_pkg.sv
// Shared types and geometry for the 2-way, 64-set, 8-byte-line data cache controller.
package dcache_pkg;

  localparam int ADDR_W          = 64;
  localparam int INDEX_W         = 6;
  localparam int OFFSET_W        = 3;
  localparam int TAG_WIDTH       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int TAG_W           = TAG_WIDTH;
  localparam int CACHELINE_WIDTH = 64;
  localparam int LINE_W          = CACHELINE_WIDTH;
  localparam int HIT_WIDTH       = 2;
  localparam int SETS            = 1 << INDEX_W;

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB_RD  = 3'd1,
    WB_CAP = 3'd2,
    WB_REQ = 3'd3,
    RF_REQ = 3'd4,
    RF_WR  = 3'd5,
    REPLAY = 3'd6
  } state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_WIDTH-1:0] tag,
                                                  input logic [INDEX_W-1:0]   index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_tagv.sv
// Tag/valid/dirty/LRU store: synchronous write, combinational read, hit compare and
// victim selection for the indexed set.
module dcache_tagv
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    index,
  input  logic [TAG_WIDTH-1:0]  tag,
  input  logic                  fill_en,
  input  logic                  fill_way,
  input  logic                  clean_en,
  input  logic                  touch_en,
  input  logic                  touch_way,
  input  logic                  touch_store,
  output logic [HIT_WIDTH-1:0]  match,
  output logic                  victim_way,
  output logic                  victim_valid,
  output logic                  victim_dirty,
  output logic [TAG_WIDTH-1:0]  victim_tag
);

  logic [TAG_WIDTH-1:0]              tag_mem [HIT_WIDTH][SETS];
  logic [HIT_WIDTH-1:0][SETS-1:0]    valid_q;
  logic [HIT_WIDTH-1:0][SETS-1:0]    dirty_q;
  logic [SETS-1:0]                   lru_q;

  always_comb begin
    match = '0;
    for (int w = 0; w < HIT_WIDTH; w++) begin
      match[w] = valid_q[w][index] && (tag_mem[w][index] == tag);
    end
  end

  // Fill empty ways first so LRU only matters once the set is full.
  always_comb begin
    if (!valid_q[0][index])      victim_way = 1'b0;
    else if (!valid_q[1][index]) victim_way = 1'b1;
    else                         victim_way = lru_q[index];
  end

  assign victim_valid = valid_q[victim_way][index];
  assign victim_dirty = dirty_q[victim_way][index];
  assign victim_tag   = tag_mem[victim_way][index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      if (fill_en) begin
        valid_q[fill_way][index] <= 1'b1;
        dirty_q[fill_way][index] <= 1'b0;
      end
      if (clean_en) begin
        dirty_q[fill_way][index] <= 1'b0;
      end
      if (touch_en) begin
        lru_q[index] <= ~touch_way;
        if (touch_store) dirty_q[touch_way][index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) tag_mem[fill_way][index] <= tag;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Data cache sequencing controller: hit detection, dirty write-back and refill over the
// bridge, pipeline stall. Optional perf counters enabled by DCACHE_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | combinational lookup; hits served, misses latched
// WB_RD  | pulse write_back to read the dirty victim from the array
// WB_CAP | capture cacheline_old into wr_data
// WB_REQ | wr_req held until wr_done, then victim marked clean
// RF_REQ | rd_req held until rd_valid, refill data latched
// RF_WR  | pulse refresh, install tag and valid for the victim way
// REPLAY | re-run lookup on the latched request (guaranteed hit)
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sram_e,
  input  logic                        sram_we,
  input  logic [ADDR_W-1:0]           sram_addr,
  output logic                        stall,
  output logic [HIT_WIDTH-1:0]        hit,
  output logic                        lru,
  output logic                        vaild,
  output logic                        dirty,
  output logic                        write_back,
  output logic                        refresh,
  input  logic [CACHELINE_WIDTH-1:0]  cacheline_old,
  output logic [CACHELINE_WIDTH-1:0]  cacheline_new,
  output logic                        rd_req,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic                        rd_valid,
  input  logic [CACHELINE_WIDTH-1:0]  rd_data,
  output logic                        wr_req,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [CACHELINE_WIDTH-1:0]  wr_data,
  input  logic                        wr_done
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [63:0]                 perf_hit,
  output logic [63:0]                 perf_miss
`endif
);

  state_t                       state_q, state_d;
  logic [ADDR_W-1:0]            addr_q;
  logic                         we_q;
  logic                         victim_q;
  logic [ADDR_W-1:0]            rd_addr_q;
  logic [ADDR_W-1:0]            wr_addr_q;
  logic [CACHELINE_WIDTH-1:0]   wr_data_q;
  logic [CACHELINE_WIDTH-1:0]   line_q;

  logic [ADDR_W-1:0]            look_addr;
  logic [INDEX_W-1:0]           look_index;
  logic [TAG_WIDTH-1:0]         look_tag;
  logic [HIT_WIDTH-1:0]         match;
  logic                         victim_way;
  logic                         victim_valid;
  logic                         victim_dirty;
  logic [TAG_WIDTH-1:0]         victim_tag;

  logic                         fill_en;
  logic                         clean_en;
  logic                         touch_en;
  logic                         touch_store;
  logic                         miss_start;
  logic                         cap_wb;
  logic                         cap_rd;

  // Outside IDLE the LSU holds its request, but the latched copy is authoritative.
  assign look_addr  = (state_q == IDLE) ? sram_addr : addr_q;
  assign look_index = look_addr[OFFSET_W +: INDEX_W];
  assign look_tag   = look_addr[ADDR_W-1 -: TAG_WIDTH];

  dcache_tagv u_tagv (
    .clk          (clk),
    .rst          (rst),
    .index        (look_index),
    .tag          (look_tag),
    .fill_en      (fill_en),
    .fill_way     (victim_q),
    .clean_en     (clean_en),
    .touch_en     (touch_en),
    .touch_way    (match[1]),
    .touch_store  (touch_store),
    .match        (match),
    .victim_way   (victim_way),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag)
  );

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    hit         = '0;
    write_back  = 1'b0;
    refresh     = 1'b0;
    rd_req      = 1'b0;
    wr_req      = 1'b0;
    fill_en     = 1'b0;
    clean_en    = 1'b0;
    touch_en    = 1'b0;
    touch_store = 1'b0;
    miss_start  = 1'b0;
    cap_wb      = 1'b0;
    cap_rd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (sram_e) begin
          if (|match) begin
            hit         = match;
            touch_en    = 1'b1;
            touch_store = sram_we;
          end else begin
            stall      = 1'b1;
            miss_start = 1'b1;
            state_d    = (victim_valid && victim_dirty) ? WB_RD : RF_REQ;
          end
        end
      end
      WB_RD: begin
        stall      = 1'b1;
        write_back = 1'b1;
        state_d    = WB_CAP;
      end
      WB_CAP: begin
        stall   = 1'b1;
        cap_wb  = 1'b1;
        state_d = WB_REQ;
      end
      WB_REQ: begin
        stall  = 1'b1;
        wr_req = 1'b1;
        if (wr_done) begin
          clean_en = 1'b1;
          state_d  = RF_REQ;
        end
      end
      RF_REQ: begin
        stall  = 1'b1;
        rd_req = 1'b1;
        if (rd_valid) begin
          cap_rd  = 1'b1;
          state_d = RF_WR;
        end
      end
      RF_WR: begin
        stall   = 1'b1;
        refresh = 1'b1;
        fill_en = 1'b1;
        state_d = REPLAY;
      end
      REPLAY: begin
        hit         = match;
        touch_en    = 1'b1;
        touch_store = we_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Bridge requests must not linger into the reset cycle.
    if (rst) begin
      rd_req = 1'b0;
      wr_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      victim_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      line_q    <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        addr_q    <= sram_addr;
        we_q      <= sram_we;
        victim_q  <= victim_way;
        rd_addr_q <= look_addr & LINE_MASK;
        wr_addr_q <= line_addr(victim_tag, look_index);
      end
      if (cap_wb) wr_data_q <= cacheline_old;
      if (cap_rd) line_q    <= rd_data;
    end
  end

  assign lru           = victim_way;
  assign vaild         = ~stall;
  assign dirty         = victim_valid & victim_dirty;
  assign cacheline_new = line_q;
  assign rd_addr       = rd_addr_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if ((state_q == IDLE) && sram_e && (|match)) perf_hit <= perf_hit + 64'd1;
      if (miss_start) perf_miss <= perf_miss + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl; perf counter scenario built with DCACHE_PERF_CNT_EN.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_e, sram_we;
  logic [63:0] sram_addr;
  logic        stall;
  logic [1:0]  hit;
  logic        lru, vaild, dirty, write_back, refresh;
  logic [63:0] cacheline_old, cacheline_new;
  logic        rd_req, rd_valid, wr_req, wr_done;
  logic [63:0] rd_addr, rd_data, wr_addr, wr_data;
`ifdef DCACHE_PERF_CNT_EN
  logic [63:0] perf_hit, perf_miss;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int          m_stall, m_wb, m_wrreq, m_refresh;
  logic [63:0] m_wraddr, m_wrdata, m_rdaddr, m_new;
  logic [1:0]  m_hit;
  logic        m_dirty;
  bit          m_timeout;

  localparam logic [63:0] GARBAGE    = 64'hBADB_ADBA_DBAD_BAD0;
  localparam logic [63:0] LINE_80    = 64'h1122_3344_5566_7788;
  localparam logic [63:0] STORE_LINE = 64'hDEAD_BEEF_CAFE_F00D;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .sram_e        (sram_e),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .stall         (stall),
    .hit           (hit),
    .lru           (lru),
    .vaild         (vaild),
    .dirty         (dirty),
    .write_back    (write_back),
    .refresh       (refresh),
    .cacheline_old (cacheline_old),
    .cacheline_new (cacheline_new),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_done       (wr_done)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .perf_hit      (perf_hit),
    .perf_miss     (perf_miss)
`endif
  );

  // One IDLE-side access; leaves the request on the bus across the following edge.
  task automatic do_access(input logic e, input logic we, input logic [63:0] a,
                           output logic st, output logic [1:0] h, output logic rq);
    @(negedge clk);
    sram_e = e; sram_we = we; sram_addr = a;
    rd_valid = 1'b0; wr_done = 1'b0; rd_data = GARBAGE; cacheline_old = GARBAGE;
    #1;
    st = stall; h = hit; rq = rd_req;
  endtask

  // Drives a miss to completion, acting as array and bridge, and records what it saw.
  task automatic run_miss(input logic [63:0] a, input logic we, input int rd_wait, input int wr_wait,
                          input logic [63:0] line, input logic [63:0] old_line);
    int  rd_cnt = 0;
    int  wr_cnt = 0;
    bit  done   = 0;
    bit  wb_prev = 0;
    m_stall = 0; m_wb = 0; m_wrreq = 0; m_refresh = 0;
    m_wraddr = '0; m_wrdata = '0; m_rdaddr = '0; m_new = '0; m_hit = '0; m_dirty = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      sram_e = 1'b1; sram_we = we; sram_addr = a;
      rd_valid = 1'b0; wr_done = 1'b0; rd_data = GARBAGE;
      cacheline_old = wb_prev ? old_line : GARBAGE;
      #1;
      if (cyc == 0) m_dirty = dirty;
      wb_prev = write_back;
      if (write_back) m_wb++;
      if (wr_req) begin
        wr_cnt++; m_wrreq++; m_wraddr = wr_addr; m_wrdata = wr_data;
        if (wr_cnt > wr_wait) wr_done = 1'b1;
      end
      if (rd_req) begin
        rd_cnt++; m_rdaddr = rd_addr;
        if (rd_cnt > rd_wait) begin rd_valid = 1'b1; rd_data = line; end
      end
      if (refresh) begin m_refresh++; m_new = cacheline_new; end
      if (stall) m_stall++;
      else begin m_hit = hit; done = 1; sram_e = 1'b0; end
    end
    m_timeout = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (hit !== 2'b00) begin n_fail++; $display("FAIL reset_hit: got %b expected 00", hit); end
    n_checks++; if (vaild !== 1'b1) begin n_fail++; $display("FAIL reset_vaild: got %b expected 1", vaild); end
    n_checks++; if ({write_back, refresh, rd_req, wr_req} !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {write_back, refresh, rd_req, wr_req}); end
    n_checks++; if ({rd_addr, wr_addr} !== 128'd0) begin n_fail++; $display("FAIL reset_addr: got %h %h expected 0 0", rd_addr, wr_addr); end
    n_checks++; if ({wr_data, cacheline_new} !== 128'd0) begin n_fail++; $display("FAIL reset_data: got %h %h expected 0 0", wr_data, cacheline_new); end
    rst = 1'b0;
  endtask

  task automatic test_cold_read();
    run_miss(64'h8000_0040, 1'b0, 2, 0, LINE_80, GARBAGE);
    n_checks++; if (m_timeout !== 1'b0) begin n_fail++; $display("FAIL cold_timeout: got %b expected 0", m_timeout); end
    n_checks++; if (m_stall !== 5) begin n_fail++; $display("FAIL cold_stall_cycles: got %0d expected 5", m_stall); end
    n_checks++; if (m_rdaddr !== 64'h8000_0040) begin n_fail++; $display("FAIL cold_rd_addr: got %h expected 80000040", m_rdaddr); end
    n_checks++; if ((m_wb !== 0) || (m_wrreq !== 0)) begin n_fail++; $display("FAIL cold_no_wb: got %0d/%0d expected 0/0", m_wb, m_wrreq); end
    n_checks++; if (m_refresh !== 1) begin n_fail++; $display("FAIL cold_refresh: got %0d expected 1", m_refresh); end
    n_checks++; if (m_new !== LINE_80) begin n_fail++; $display("FAIL cold_line_new: got %h expected %h", m_new, LINE_80); end
    n_checks++; if (m_hit !== 2'b01) begin n_fail++; $display("FAIL cold_replay_hit: got %b expected 01", m_hit); end
  endtask

  task automatic test_hit();
    logic st, rq; logic [1:0] h;
    do_access(1'b1, 1'b0, 64'h8000_0040, st, h, rq);
    n_checks++; if (st !== 1'b0) begin n_fail++; $display("FAIL hit_stall: got %b expected 0", st); end
    n_checks++; if (h !== 2'b01) begin n_fail++; $display("FAIL hit_way: got %b expected 01", h); end
    n_checks++; if (rq !== 1'b0) begin n_fail++; $display("FAIL hit_no_rd_req: got %b expected 0", rq); end
    n_checks++; if (vaild !== 1'b1) begin n_fail++; $display("FAIL hit_vaild: got %b expected 1", vaild); end
    do_access(1'b0, 1'b0, 64'h8000_0040, st, h, rq);
    n_checks++; if (h !== 2'b00) begin n_fail++; $display("FAIL idle_no_hit: got %b expected 00", h); end
    n_checks++; if (lru !== 1'b1) begin n_fail++; $display("FAIL hit_lru_set8: got %b expected 1", lru); end
  endtask

  task automatic test_dirty_evict();
    logic st, rq; logic [1:0] h;
    do_access(1'b1, 1'b1, 64'h8000_0040, st, h, rq);
    n_checks++; if (h !== 2'b01) begin n_fail++; $display("FAIL store_hit: got %b expected 01", h); end
    run_miss(64'h9000_0040, 1'b0, 0, 0, 64'h9999_0000_9999_0000, GARBAGE);
    n_checks++; if (m_stall !== 3) begin n_fail++; $display("FAIL fill_way1_stall: got %0d expected 3", m_stall); end
    n_checks++; if (m_hit !== 2'b10) begin n_fail++; $display("FAIL fill_way1_hit: got %b expected 10", m_hit); end
    run_miss(64'hA000_0040, 1'b0, 0, 0, 64'hAAAA_0000_AAAA_0000, STORE_LINE);
    n_checks++; if (m_timeout !== 1'b0) begin n_fail++; $display("FAIL dirty_timeout: got %b expected 0", m_timeout); end
    n_checks++; if (m_dirty !== 1'b1) begin n_fail++; $display("FAIL dirty_flag: got %b expected 1", m_dirty); end
    n_checks++; if (m_wb !== 1) begin n_fail++; $display("FAIL dirty_write_back: got %0d expected 1", m_wb); end
    n_checks++; if (m_wraddr !== 64'h8000_0040) begin n_fail++; $display("FAIL dirty_wr_addr: got %h expected 80000040", m_wraddr); end
    n_checks++; if (m_wrdata !== STORE_LINE) begin n_fail++; $display("FAIL dirty_wr_data: got %h expected %h", m_wrdata, STORE_LINE); end
    n_checks++; if (m_wrreq !== 1) begin n_fail++; $display("FAIL dirty_wr_req_cycles: got %0d expected 1", m_wrreq); end
    n_checks++; if (m_stall !== 6) begin n_fail++; $display("FAIL dirty_stall_cycles: got %0d expected 6", m_stall); end
    n_checks++; if (m_rdaddr !== 64'hA000_0040) begin n_fail++; $display("FAIL dirty_rd_addr: got %h expected a0000040", m_rdaddr); end
    n_checks++; if (m_hit !== 2'b01) begin n_fail++; $display("FAIL dirty_replay_hit: got %b expected 01", m_hit); end
  endtask

  task automatic test_clean_evict();
    run_miss(64'hB000_0040, 1'b0, 0, 0, 64'hBBBB_0000_BBBB_0000, GARBAGE);
    n_checks++; if (m_dirty !== 1'b0) begin n_fail++; $display("FAIL clean_dirty_flag: got %b expected 0", m_dirty); end
    n_checks++; if ((m_wb !== 0) || (m_wrreq !== 0)) begin n_fail++; $display("FAIL clean_no_wb: got %0d/%0d expected 0/0", m_wb, m_wrreq); end
    n_checks++; if (m_stall !== 3) begin n_fail++; $display("FAIL clean_stall_cycles: got %0d expected 3", m_stall); end
    n_checks++; if (m_hit !== 2'b10) begin n_fail++; $display("FAIL clean_replay_hit: got %b expected 10", m_hit); end
  endtask

  task automatic test_spurious();
    logic st, rq; logic [1:0] h;
    @(negedge clk);
    sram_e = 1'b0; rd_valid = 1'b1; wr_done = 1'b1; rd_data = GARBAGE;
    do_access(1'b0, 1'b0, 64'h0, st, h, rq);
    n_checks++; if ({st, rq, wr_req, refresh} !== 4'b0000) begin n_fail++; $display("FAIL spurious_ignored: got %b expected 0000", {st, rq, wr_req, refresh}); end
    do_access(1'b1, 1'b0, 64'hA000_0040, st, h, rq);
    n_checks++; if ({st, h} !== 3'b001) begin n_fail++; $display("FAIL spurious_then_hit: got %b expected 001", {st, h}); end
  endtask

  task automatic test_back_to_back();
    logic st, rq; logic [1:0] h1, h2, h;
    do_access(1'b1, 1'b0, 64'hA000_0040, st, h1, rq);
    do_access(1'b1, 1'b0, 64'hB000_0040, st, h2, rq);
    do_access(1'b0, 1'b0, 64'hA000_0040, st, h, rq);
    n_checks++; if ({h1, h2} !== 4'b0110) begin n_fail++; $display("FAIL b2b_hits_ab: got %b expected 0110", {h1, h2}); end
    n_checks++; if (lru !== 1'b0) begin n_fail++; $display("FAIL b2b_lru_ab: got %b expected 0", lru); end
    do_access(1'b1, 1'b0, 64'hB000_0040, st, h1, rq);
    do_access(1'b1, 1'b0, 64'hA000_0040, st, h2, rq);
    do_access(1'b0, 1'b0, 64'hA000_0040, st, h, rq);
    n_checks++; if ({h1, h2} !== 4'b1001) begin n_fail++; $display("FAIL b2b_hits_ba: got %b expected 1001", {h1, h2}); end
    n_checks++; if (lru !== 1'b1) begin n_fail++; $display("FAIL b2b_lru_ba: got %b expected 1", lru); end
  endtask

  task automatic test_reset_mid_miss();
    logic st, rq; logic [1:0] h;
    bit found = 0;
    do_access(1'b1, 1'b1, 64'hB000_0040, st, h, rq);
    do_access(1'b1, 1'b1, 64'hA000_0040, st, h, rq);
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      sram_e = 1'b1; sram_we = 1'b0; sram_addr = 64'hC000_0040;
      rd_valid = 1'b0; wr_done = 1'b0; cacheline_old = STORE_LINE;
      #1;
      if (wr_req) found = 1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_wb_req: got %b expected 1", found); end
    @(negedge clk);
    rst = 1'b1; #1;
    n_checks++; if ({wr_req, rd_req} !== 2'b00) begin n_fail++; $display("FAIL rstmid_req_drop: got %b expected 00", {wr_req, rd_req}); end
    @(negedge clk);
    rst = 1'b0; sram_e = 1'b0; #1;
    n_checks++; if ({stall, wr_req, rd_req} !== 3'b000) begin n_fail++; $display("FAIL rstmid_idle: got %b expected 000", {stall, wr_req, rd_req}); end
    run_miss(64'hA000_0040, 1'b0, 0, 0, 64'h5A5A_5A5A_5A5A_5A5A, GARBAGE);
    n_checks++; if (m_stall !== 3) begin n_fail++; $display("FAIL rstmid_first_miss_stall: got %0d expected 3", m_stall); end
    n_checks++; if ((m_wb !== 0) || (m_dirty !== 1'b0)) begin n_fail++; $display("FAIL rstmid_no_dirty: got %0d/%b expected 0/0", m_wb, m_dirty); end
    n_checks++; if (m_hit !== 2'b01) begin n_fail++; $display("FAIL rstmid_replay_way0: got %b expected 01", m_hit); end
  endtask

`ifdef DCACHE_PERF_CNT_EN
  task automatic test_perf();
    logic st, rq; logic [1:0] h;
    @(negedge clk); rst = 1'b1; sram_e = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if ({perf_hit, perf_miss} !== 128'd0) begin n_fail++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_hit, perf_miss); end
    run_miss(64'h1000_0000, 1'b0, 0, 0, 64'h1, GARBAGE);
    run_miss(64'h1000_0008, 1'b0, 1, 0, 64'h2, GARBAGE);
    run_miss(64'h1000_0010, 1'b0, 0, 0, 64'h3, GARBAGE);
    do_access(1'b1, 1'b0, 64'h1000_0000, st, h, rq);
    do_access(1'b1, 1'b0, 64'h1000_0008, st, h, rq);
    do_access(1'b1, 1'b1, 64'h1000_0010, st, h, rq);
    do_access(1'b1, 1'b0, 64'h1000_0000, st, h, rq);
    do_access(1'b1, 1'b0, 64'h1000_0000, st, h, rq);
    do_access(1'b0, 1'b0, 64'h0, st, h, rq);
    n_checks++; if (perf_miss !== 64'd3) begin n_fail++; $display("FAIL perf_miss: got %0d expected 3", perf_miss); end
    n_checks++; if (perf_hit !== 64'd5) begin n_fail++; $display("FAIL perf_hit: got %0d expected 5", perf_hit); end
  endtask
`endif

  initial begin
    rst = 1'b1; sram_e = 1'b0; sram_we = 1'b0; sram_addr = '0;
    cacheline_old = '0; rd_valid = 1'b0; rd_data = '0; wr_done = 1'b0;
    test_reset();
    test_cold_read();
    test_hit();
    test_dirty_evict();
    test_clean_evict();
    test_spurious();
    test_back_to_back();
    test_reset_mid_miss();
`ifdef DCACHE_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Sequencing controller for the 2-way, 64-set, 8-byte-line data cache array.
- Holds the tag, valid, dirty and LRU state.
- Performs hit detection for the LSU sram-style request.
- Drives hit/lru/vaild/write_back/refresh into the data array.
- Runs dirty-victim write-back and line refill over a simple AXI-side request/response bridge.
- Stalls the pipeline while a miss is being serviced.

Parameters:
ADDR_W, 64, request address width
INDEX_W, 6, set index bits (64 sets)
OFFSET_W, 3, byte offset bits (8-byte line)
TAG_W, ADDR_W-INDEX_W-OFFSET_W (55), tag bits
LINE_W, 64, cacheline width (equals CACHELINE_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
sram_e  in  1  LSU access enable
sram_we  in  1  LSU write
sram_addr  in  64  LSU address
stall  out  1  pipeline stall; LSU holds request stable while high
hit  out  2  one-hot way hit to data array (0 on miss)
lru  out  1  victim way for indexed set
vaild  out  1  set access valid to data array
dirty  out  1  victim dirty flag
write_back  out  1  read victim line from array (1 cycle)
refresh  out  1  write cacheline_new into victim way (1 cycle)
cacheline_old  in  LINE_W  victim data from array, valid the cycle after write_back
cacheline_new  out  LINE_W  refill data to array
rd_req  out  1  refill read request, held until rd_valid
rd_addr  out  64  line-aligned refill address
rd_valid  in  1  refill data valid (single beat)
rd_data  in  LINE_W  refill data
wr_req  out  1  write-back request, held until wr_done
wr_addr  out  64  line-aligned victim address {tag_victim,index,3'b0}
wr_data  out  LINE_W  victim line, registered
wr_done  in  1  write-back accepted

Behaviour:
- Reset: state IDLE; all valid, dirty and LRU bits cleared. Outputs stall, hit, write_back, refresh, rd_req, wr_req are 0; vaild=1; addresses and data are 0.
- Address split: {tag, index, offset} = sram_addr.
- Lookup is combinational in IDLE: hit[w] = sram_e & valid[w][index] & tag[w][index]==tag.
- Hit, IDLE: stall=0, hit driven, data returned by the array next cycle. LRU[index] is set to the other way. Store sets dirty[way][index].
- Miss (sram_e & hit==0): stall=1 the same cycle; latch addr, we, index and victim way=lru[index]. The victim is way 0 if valid[0]=0, else way 1 if valid[1]=0.
- FSM states and transitions:
  - IDLE: miss & victim valid & dirty -> WB_RD; miss otherwise -> RF_REQ.
  - WB_RD: write_back=1 for 1 cycle -> WB_CAP.
  - WB_CAP: capture cacheline_old into wr_data -> WB_REQ.
  - WB_REQ: wr_req=1 until wr_done; then clear dirty -> RF_REQ.
  - RF_REQ: rd_req=1, rd_addr={tag,index,3'b0} until rd_valid; latch rd_data -> RF_WR.
  - RF_WR: refresh=1 for 1 cycle, cacheline_new=latched data. Write tag, set valid, clear dirty -> REPLAY.
  - REPLAY: stall=0, re-assert lookup (now a guaranteed hit), update LRU and dirty as for a hit -> IDLE.
- Minimum miss latency: 3 cycles clean (RF_REQ with rd_valid same cycle, RF_WR, REPLAY); 6 cycles dirty.
- rd_valid or wr_done arriving in a state not waiting for it is ignored.
- sram_e low in IDLE: no array enable, no state change.
- rst mid-miss: FSM returns to IDLE next edge; rd_req and wr_req drop immediately. Outstanding bridge responses are dropped by the bridge on the same reset.
- Back-to-back hits to the same set update LRU each cycle; last access wins.

Optional Feature:
- DCACHE_PERF_CNT_EN defined:
  - Adds outputs perf_hit[63:0] and perf_miss[63:0], both reset to 0.
  - perf_hit increments on each IDLE hit; perf_miss increments on each IDLE miss entry.
  - REPLAY is not counted.
  - Counters wrap modulo 2^64.
- Not defined: ports and logic are absent.

Decomposition:
- Shared package/defines:
  - HIT_WIDTH=2, TAG_WIDTH, CACHELINE_WIDTH, INDEX_W, OFFSET_W.
  - FSM state encoding localparams: IDLE=0, WB_RD, WB_CAP, WB_REQ, RF_REQ, RF_WR, REPLAY.
- One natural sub-module, dcache_tagv: two ways of 64×(TAG_W+valid+dirty) plus 64 LRU bits.
  - Synchronous write, combinational read.
  - Owns hit compare and victim selection.

Test Plan:
- Cold read 0x8000_0040: stall=1, rd_req with rd_addr=0x8000_0040; rd_valid after 2 cycles with 0x1122334455667788 -> refresh=1 into way0; REPLAY gives hit=2'b01, stall drops.
- Repeat read 0x8000_0040 -> hit=2'b01, stall=0 same cycle, no rd_req; LRU[8]=1.
- Store to 0x8000_0040, then read 0x9000_0040 and 0xA000_0040 (same set 8) -> second miss evicts way0.
  - Requires write_back pulse, wr_addr=0x8000_0040, wr_data equals stored line, then refill.
- Clean victim eviction -> no write_back and no wr_req; refill only, 3-cycle stall with immediate rd_valid.
- rst asserted while in WB_REQ -> next cycle state IDLE, wr_req=0, valid bits all 0, first access misses.
- With DCACHE_PERF_CNT_EN: 3 misses and 5 hits -> perf_miss=3, perf_hit=5.
